led_matrix_pwm: RTL and testbench
=================================

// Module: led_matrix_pwm
// PURPOSE
//  Parametrised, double-buffered scanning driver for a row/column multiplexed LED matrix with per-pixel PWM grayscale.
//  Sits between the pixel source (pattern generator / CPU regs) and the matrix pins; images load via valid/ready
//  into a pending buffer and are promoted only at frame boundaries, so there is no tearing.
// PARAMETERS
//  ROWS          6   matrix rows (scanned, one active at a time), >=1
//  COLS          6   matrix columns (driven in parallel), >=1
//  BPP           4   bits of brightness per pixel, 1..8; 0=off, 2^BPP-1=full on
//  SLOT_CYCLES   64  clk cycles per PWM slot, >=1
//  BLANK_CYCLES  16  clk cycles, all outputs off, before each row (anti-ghosting), >=1
// PORTS
//  clk          in   1               system clock
//  rst          in   1               synchronous reset, active-high
//  img          in   ROWS*COLS*BPP   pixel (r,c) = img[(r*COLS+c)*BPP +: BPP]; row 0 in LSBs
//  img_valid    in   1               img holds a new frame
//  img_ready    out  1               pending buffer empty; capture when img_valid&&img_ready
//  row          out  ROWS            one-hot row enable, active-high; all 0 while blanking
//  col          out  COLS            column drive, active-high
//  frame_start  out  1               1-cycle pulse: first cycle of row 0 blanking
// BEHAVIOUR
//  - Reset: row=0, col=0, frame_start=0, img_ready=1, active and pending buffers=0, pending_full=0,
//    FSM=BLANK, row_idx=0, counters=0. The first cycle after rst deasserts is BLANK cycle 0 of row 0.
//  - FSM BLANK: row=0, col=0 for BLANK_CYCLES cycles, then DRIVE with slot=0.
//  - FSM DRIVE: row[row_idx]=1; col[c]=(slot < pix(row_idx,c)); each slot lasts SLOT_CYCLES cycles; slots run
//    0..2^BPP-2. After the last slot: row_idx wraps to 0 after ROWS-1, else increments; FSM returns to BLANK.
//  - Row period = BLANK_CYCLES+(2^BPP-1)*SLOT_CYCLES cycles; frame = ROWS * row period. Duty = pix/(2^BPP-1).
//  - All outputs are registered: the FSM state in cycle N drives the pins in cycle N+1. frame_start goes high
//    in the cycle in which row=0 first shows blanking of row 0.
//  - Load: img_valid&&img_ready copies img into pending; pending_full<=1; img_ready<=0 next cycle.
//    img_valid while img_ready=0 is ignored (the source holds it). No combinational path from img_valid to img_ready.
//  - Promotion: on the last cycle of the last slot of row ROWS-1, if pending_full then active<=pending and
//    pending_full<=0; img_ready=1 the next cycle. A capture in that same cycle (pending was empty) lands in pending
//    and is promoted at the next frame end. The active buffer never changes mid-frame.
//  - rst mid-frame: immediate return to the reset state; a pending frame is discarded.
//  - Counter widths are $clog2-based with a minimum of 1 bit; the slot compare is BPP-bit unsigned.
// CONFIGURATION
//  LED_MATRIX_PWM_DIM_EN defined: adds port dim (in, BPP) for global brightness. Lit iff slot < min(pix, dim).
//    dim is sampled only at the start of each row (BLANK cycle 0), so a row never changes mid-scan.
//  LED_MATRIX_PWM_DIM_EN undefined: no dim port; behaves as dim = 2^BPP-1.
// STRUCTURE
//  Package led_matrix_pkg: state enum {BLANK, DRIVE}; functions for row_period/frame_period and ctr width.
//  Sub-module led_frame_buffer: pending+active registers, valid/ready capture, promote strobe input.
//  The top level holds the FSM, the slot/cycle/row counters and the output registers.
// TESTING (ROWS=2, COLS=3, BPP=2, SLOT_CYCLES=2, BLANK_CYCLES=1 -> row 7 cycles, frame 14)
//  1 Reset: hold rst 3 cycles -> row=0, col=0, img_ready=1; frame_start at 1st cycle after release, then every 14.
//  2 Load pix r0={0,1,3}, r1={2,2,0} -> row=01: col0 0/6, col1 2/6, col2 6/6 cycles lit; row=10: col0,col1 4/6.
//  3 Tearing: load frame B mid-frame -> img_ready=0 until frame end; pins unchanged until frame_start, then show B.
//  4 Back-to-back valid with ready low -> second image ignored; it is captured the cycle after img_ready rises.
//  5 Assert rst during row 1 slot 2 -> outputs zero next cycle; pending dropped; active=0; restart at row 0.
//  6 DIM_EN build, dim=1, all pix=3 -> each col lit 2 of 6 drive cycles; change dim mid-row -> applied next row only.
//  Checker: at most one row bit high; row=0 implies col=0; no col change within a slot.

Source files
------------

// File: rtl/led_matrix_pkg.sv
// Shared types and sizing helpers for the LED matrix PWM scanner.
// Optional feature macro used by the top level: LED_MATRIX_PWM_DIM_EN (global dim input).
package led_matrix_pkg;

  // Scanner phase: outputs dark (BLANK) or one row lit with PWM columns (DRIVE).
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  // Counter width for a counter that must hold values 0..n-1, never narrower than 1 bit.
  function automatic int ctr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Clock cycles spent on one row: blanking plus all PWM slots.
  function automatic int row_period(input int blank_cycles, input int slot_cycles, input int bpp);
    return blank_cycles + ((1 << bpp) - 1) * slot_cycles;
  endfunction

  // Clock cycles for a complete scan of every row.
  function automatic int frame_period(input int rows, input int blank_cycles,
                                      input int slot_cycles, input int bpp);
    return rows * row_period(blank_cycles, slot_cycles, bpp);
  endfunction

endpackage

// File: rtl/led_matrix_pwm_frame_buffer.sv
// Double image buffer: a pending slot filled over valid/ready and an active slot
// that only changes when the scanner strobes i_promote at the end of a frame.
module led_frame_buffer
  import led_matrix_pkg::*;
#(
  parameter int W = 144
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_img,
  input  logic         i_img_valid,
  input  logic         i_promote,
  output logic         o_img_ready,
  output logic [W-1:0] o_active
);

  logic [W-1:0] r_pending;
  logic [W-1:0] r_active;
  logic         r_pending_full;

  // Capture into the empty pending slot, or move a full pending slot to active at frame end.
  always_ff @(posedge clk) begin
    // NOTE: every register here is state, so it is written with <= to avoid ordering races between blocks.
    if (rst) begin
      // NOTE: both image buffers are cleared on reset so a restarted matrix shows black, not stale pixels.
      r_pending      <= '0;
      r_active       <= '0;
      r_pending_full <= 1'b0;
    end else if (i_img_valid && !r_pending_full) begin
      // A capture can coincide with the promote strobe only while pending is empty,
      // so the new image simply waits for the following frame end.
      r_pending      <= i_img;
      r_pending_full <= 1'b1;
    end else if (i_promote && r_pending_full) begin
      r_active       <= r_pending;
      r_pending_full <= 1'b0;
    end
  end

  // Ready comes straight from a flop: there is no path from i_img_valid to o_img_ready.
  assign o_img_ready = !r_pending_full;
  assign o_active    = r_active;

endmodule

// File: rtl/led_matrix_pwm.sv
// Scanning PWM driver for a row/column multiplexed LED matrix.
// Each row gets BLANK_CYCLES dark cycles, then 2^BPP-1 PWM slots of SLOT_CYCLES each.
// Define LED_MATRIX_PWM_DIM_EN to add the global 'dim' brightness input.
module led_matrix_pwm
  import led_matrix_pkg::*;
#(
  parameter int ROWS         = 6,
  parameter int COLS         = 6,
  parameter int BPP          = 4,
  parameter int SLOT_CYCLES  = 64,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ROWS*COLS*BPP-1:0] img,
  input  logic                     img_valid,
  output logic                     img_ready,
`ifdef LED_MATRIX_PWM_DIM_EN
  input  logic [BPP-1:0]           dim,
`endif
  output logic [ROWS-1:0]          row,
  output logic [COLS-1:0]          col,
  output logic                     frame_start
);

  localparam int ROW_W = ctr_w(ROWS);
  localparam int CYC_W = ctr_w((BLANK_CYCLES > SLOT_CYCLES) ? BLANK_CYCLES : SLOT_CYCLES);

  localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(ROWS - 1);
  localparam logic [CYC_W-1:0] BLANK_LAST    = CYC_W'(BLANK_CYCLES - 1);
  localparam logic [CYC_W-1:0] SLOT_CYC_LAST = CYC_W'(SLOT_CYCLES - 1);
  localparam logic [BPP-1:0]   SLOT_LAST     = BPP'((1 << BPP) - 2);

  state_t                   r_state;
  logic [ROW_W-1:0]         r_row_idx;
  logic [CYC_W-1:0]         r_cyc;
  logic [BPP-1:0]           r_slot;
  logic [ROWS-1:0]          r_row;
  logic [COLS-1:0]          r_col;
  logic                     r_frame_start;

  logic [ROWS*COLS*BPP-1:0] w_active;
  logic                     w_promote;
  logic [BPP-1:0]           w_dim;
  logic [COLS-1:0]          w_col_lit;
  logic [ROWS-1:0]          w_row_onehot;

`ifdef LED_MATRIX_PWM_DIM_EN
  logic [BPP-1:0]           r_dim;
  assign w_dim = r_dim;
`else
  assign w_dim = '1;
`endif

  // The last cycle of the last slot of the last row closes the frame.
  assign w_promote = (r_state == ST_DRIVE) && (r_row_idx == ROW_LAST) &&
                     (r_slot == SLOT_LAST) && (r_cyc == SLOT_CYC_LAST);

  assign w_row_onehot = ROWS'(1) << r_row_idx;

  led_frame_buffer #(
    .W (ROWS*COLS*BPP)
  ) u_frame_buffer (
    .clk         (clk),
    .rst         (rst),
    .i_img       (img),
    .i_img_valid (img_valid),
    .i_promote   (w_promote),
    .o_img_ready (img_ready),
    .o_active    (w_active)
  );

  // Column PWM compare for the current row: lit while slot < min(pixel, dim).
  always_comb begin
    logic [BPP-1:0] w_pix;
    logic [BPP-1:0] w_thresh;
    int             w_base;
    // NOTE: every variable gets a value before any branch so no latch can be inferred.
    w_col_lit = '0;
    w_pix     = '0;
    w_thresh  = '0;
    w_base    = 0;
    for (int c = 0; c < COLS; c++) begin
      w_base       = (int'(r_row_idx) * COLS + c) * BPP;
      w_pix        = w_active[w_base +: BPP];
      w_thresh     = (w_pix < w_dim) ? w_pix : w_dim;
      w_col_lit[c] = (r_slot < w_thresh);
    end
  end

  // Scan FSM with counters and registered pin outputs (pins lag the state by one cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_BLANK;
      r_row_idx     <= '0;
      r_cyc         <= '0;
      r_slot        <= '0;
      r_row         <= '0;
      r_col         <= '0;
      r_frame_start <= 1'b0;
`ifdef LED_MATRIX_PWM_DIM_EN
      r_dim         <= '1;
`endif
    end else begin
      r_frame_start <= (r_state == ST_BLANK) && (r_cyc == '0) && (r_row_idx == '0);
      r_row         <= (r_state == ST_DRIVE) ? w_row_onehot : '0;
      r_col         <= (r_state == ST_DRIVE) ? w_col_lit : '0;

      case (r_state)
        ST_BLANK: begin
`ifdef LED_MATRIX_PWM_DIM_EN
          // Dim is frozen for the whole row at its first blank cycle.
          if (r_cyc == '0) r_dim <= dim;
`endif
          if (r_cyc == BLANK_LAST) begin
            r_cyc   <= '0;
            r_slot  <= '0;
            r_state <= ST_DRIVE;
          end else begin
            r_cyc <= r_cyc + CYC_W'(1);
          end
        end
        ST_DRIVE: begin
          if (r_cyc == SLOT_CYC_LAST) begin
            r_cyc <= '0;
            if (r_slot == SLOT_LAST) begin
              r_state   <= ST_BLANK;
              r_row_idx <= (r_row_idx == ROW_LAST) ? '0 : r_row_idx + ROW_W'(1);
            end else begin
              r_slot <= r_slot + BPP'(1);
            end
          end else begin
            r_cyc <= r_cyc + CYC_W'(1);
          end
        end
        default: r_state <= ST_BLANK;
      endcase
    end
  end

  assign row         = r_row;
  assign col         = r_col;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_led_matrix_pwm.sv
// Self-checking bench for led_matrix_pwm (ROWS=2, COLS=3, BPP=2, SLOT=2, BLANK=1).
// Reference model: pin values derived from the cycle position within the frame plus a
// frame-level model of the pending/active image buffers.
module tb_led_matrix_pwm;

  localparam int ROWS  = 2;
  localparam int COLS  = 3;
  localparam int BPP   = 2;
  localparam int SLOT  = 2;
  localparam int BLANK = 1;
  localparam int ROWP  = BLANK + ((1 << BPP) - 1) * SLOT;
  localparam int FRAME = ROWS * ROWP;
  localparam int IW    = ROWS * COLS * BPP;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [IW-1:0]   img = '0;
  logic            img_valid = 1'b0;
  logic            img_ready;
  logic [ROWS-1:0] row;
  logic [COLS-1:0] col;
  logic            frame_start;
`ifdef LED_MATRIX_PWM_DIM_EN
  logic [BPP-1:0]  dim = '1;
`endif

  always #5 clk = ~clk;

  led_matrix_pwm #(
    .ROWS         (ROWS),
    .COLS         (COLS),
    .BPP          (BPP),
    .SLOT_CYCLES  (SLOT),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .img         (img),
    .img_valid   (img_valid),
    .img_ready   (img_ready),
`ifdef LED_MATRIX_PWM_DIM_EN
    .dim         (dim),
`endif
    .row         (row),
    .col         (col),
    .frame_start (frame_start)
  );

  // Reference model state
  logic [IW-1:0]  m_active  = '0;
  logic [IW-1:0]  m_pending = '0;
  bit             m_full    = 1'b0;
  int             m_k       = 0;
  logic [BPP-1:0] m_dim     = '1;
  int             lit_cnt [ROWS][COLS];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h k=%0d", tag, obs, exp, m_k);
    end
  endtask

  task automatic clear_cnt();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        lit_cnt[r][c] = 0;
  endtask

  // One clock edge: update the model for that edge, then compare the pins 1 time unit later.
  task automatic step();
    int f, r, w, slot;
    bit full_before;
    logic [ROWS-1:0] e_row;
    logic [COLS-1:0] e_col;
    logic [BPP-1:0] pix, thr;
    @(posedge clk);
    if (rst) begin
      m_k = 0; m_active = '0; m_pending = '0; m_full = 1'b0; m_dim = '1;
      #1;
      check("rst_row", 32'(row), 0);
      check("rst_col", 32'(col), 0);
      check("rst_frame_start", 32'(frame_start), 0);
      check("rst_img_ready", 32'(img_ready), 1);
      return;
    end
    f = m_k % FRAME;
    r = f / ROWP;
    w = f % ROWP;
`ifdef LED_MATRIX_PWM_DIM_EN
    if (w == 0) m_dim = dim;
`endif
    full_before = m_full;
    if (img_valid && !full_before) begin
      m_pending = img;
      m_full    = 1'b1;
    end
    e_row = '0;
    e_col = '0;
    if (w >= BLANK) begin
      slot     = (w - BLANK) / SLOT;
      e_row[r] = 1'b1;
      for (int c = 0; c < COLS; c++) begin
        pix      = m_active[(r * COLS + c) * BPP +: BPP];
        thr      = (pix < m_dim) ? pix : m_dim;
        e_col[c] = (slot < int'(thr));
      end
    end
    if (f == FRAME - 1 && full_before) begin
      m_active = m_pending;
      m_full   = 1'b0;
    end
    m_k++;
    #1;
    check("row", 32'(row), 32'(e_row));
    check("col", 32'(col), 32'(e_col));
    check("frame_start", 32'(frame_start), 32'(f == 0));
    check("img_ready", 32'(img_ready), 32'(!m_full));
    check("row_onehot0", 32'($onehot0(row)), 1);
    check("blank_col_off", 32'(row == '0 && col != '0), 0);
    for (int rr = 0; rr < ROWS; rr++)
      for (int c = 0; c < COLS; c++)
        if (row[rr] && col[c]) lit_cnt[rr][c]++;
  endtask

  task automatic to_frame_start();
    int n = 0;
    while ((m_k % FRAME) != 0 && n < 2 * FRAME) begin
      step();
      n++;
    end
    check("frame_align_bound", 32'(m_k % FRAME), 0);
  endtask

  task automatic check_counts(input string tag, input int exp_cnt [ROWS][COLS]);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        check($sformatf("%s_r%0dc%0d", tag, r, c), 32'(lit_cnt[r][c]), 32'(exp_cnt[r][c]));
  endtask

  // Image A: r0 = {0,1,3}, r1 = {2,2,0}; pixel (r,c) at bits (r*COLS+c)*BPP
  localparam logic [IW-1:0] IMG_A = {2'd0, 2'd2, 2'd2, 2'd3, 2'd1, 2'd0};
  int exp_a    [ROWS][COLS] = '{'{0, 2, 6}, '{4, 4, 0}};
  int exp_zero [ROWS][COLS] = '{'{0, 0, 0}, '{0, 0, 0}};
`ifdef LED_MATRIX_PWM_DIM_EN
  int exp_dim  [ROWS][COLS] = '{'{2, 2, 2}, '{4, 4, 4}};
`endif

  initial begin
    int n;

    // 1: reset held 3 cycles, then idle frames with the all-zero image
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (2 * FRAME + 2) step();

    // 2: load image A, wait for its promotion, count lit cycles over one frame
    img = IMG_A; img_valid = 1'b1;
    step();
    img_valid = 1'b0;
    to_frame_start();
    clear_cnt();
    repeat (FRAME) step();
    check_counts("lit_a", exp_a);

    // 3: tearing - load B mid-frame; model holds pins on A until the frame boundary
    repeat (5) step();
    img = IW'($urandom); img_valid = 1'b1;
    step();
    img_valid = 1'b0;
    check("tear_ready_low", 32'(img_ready), 0);
    to_frame_start();
    repeat (FRAME) step();

    // 4: back-to-back - C captured, D held while ready low, D captured after ready rises
    repeat (3) step();
    img = IW'($urandom); img_valid = 1'b1;
    step();
    img = IW'($urandom);
    n = 0;
    while (!img_ready && n < 2 * FRAME) begin
      step();
      n++;
    end
    check("btb_ready_wait", 32'(img_ready), 1);
    step();
    img_valid = 1'b0;
    check("btb_second_captured", 32'(img_ready), 0);
    to_frame_start();
    repeat (2 * FRAME) step();

    // Randomized loading traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) img = IW'($urandom);
      img_valid = 1'($urandom_range(0, 1));
      step();
    end
    img_valid = 1'b0;

    // 5: reset during row 1 slot 2 with a pending frame; everything returns to zero
    to_frame_start();
    img = IW'($urandom); img_valid = 1'b1;
    step();
    img_valid = 1'b0;
    n = 0;
    while ((m_k % FRAME) != (ROWP + BLANK + 2 * SLOT) && n < 2 * FRAME) begin
      step();
      n++;
    end
    check("rst_align_bound", 32'(m_k % FRAME), 32'(ROWP + BLANK + 2 * SLOT));
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_cnt();
    repeat (2 * FRAME) step();
    check_counts("lit_after_rst", exp_zero);

`ifdef LED_MATRIX_PWM_DIM_EN
    // 6: dim = 1 on a full-white image, raised to 2 mid row 0 -> only row 1 sees it
    img = '1; img_valid = 1'b1; dim = BPP'(1);
    step();
    img_valid = 1'b0;
    to_frame_start();
    repeat (FRAME) step();
    clear_cnt();
    repeat (3) step();
    dim = BPP'(2);
    repeat (FRAME - 3) step();
    check_counts("lit_dim", exp_dim);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
